// File: rtl/serdes_pkg.sv
// Shared serdes types: the framing state enum used by both serializer and deserializer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package serdes_pkg;

  // Word framing states common to both directions of the serdes pair.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for bit 0 of a new word
    SHIFT = 2'd1,  // word partially transferred
    FULL  = 2'd2   // complete word held, waiting for the far side
  } serdes_state_t;

  // Bit-index width for a word of len bits (len >= 2).
  function automatic int bit_idx_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/serdes_bit_counter.sv
// Bit-position counter for serdes framing, with synchronous clear and terminal-count flag.
// Latency: count updates on the clock edge after i_inc/i_clr; o_tc is combinational from the count.
// Backpressure: none; the owner gates i_inc with its own handshake.
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (count -> 0)
//   i_inc        : advance the count by one
//   i_clr        : return the count to 0 (wins over i_inc)
//   ov_cnt       : current bit index
//   o_tc         : count is at LENGTH-1 (last bit of the word)
module serdes_bit_counter
  import serdes_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_inc,
  input  logic                      i_clr,
  output logic [$clog2(LENGTH)-1:0] ov_cnt,
  output logic                      o_tc
);

  localparam int CW = bit_idx_w(LENGTH);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign ov_cnt = cnt_q;
  assign o_tc   = (cnt_q == CW'(LENGTH - 1));

endmodule

// File: rtl/deserializer_fsm.sv
// Serial-to-parallel deserializer: assembles LENGTH bits (LSB first) into one word.
// Latency: o_dout_valid rises one cycle after the LENGTH-th accepted bit; min word period LENGTH+1.
// Backpressure: o_ready drops while a finished word waits for i_ready; i_en low freezes everything.
//
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_en           : global enable; low holds all state
//   i_din          : serial data bit
//   i_din_valid    : i_din carries a valid bit
//   o_ready        : a serial bit can be accepted this cycle
//   ov_dout        : assembled parallel word
//   o_dout_valid   : ov_dout holds a complete word
//   i_ready        : downstream takes ov_dout when o_dout_valid is high
module deserializer_fsm
  import serdes_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready
);

  localparam int CW = bit_idx_w(LENGTH);

  serdes_state_t     state_q, state_d;
  logic [LENGTH-1:0] word_q, word_d;
  logic [CW-1:0]     cnt;
  logic              cnt_tc;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              accept;

  serdes_bit_counter #(
    .LENGTH (LENGTH)
  ) u_bit_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (cnt_inc),
    .i_clr  (cnt_clr),
    .ov_cnt (cnt),
    .o_tc   (cnt_tc)
  );

  // o_ready already folds in i_en and reset, so accept is the full handshake.
  assign accept = i_din_valid & o_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        // Counter is always 0 here, so bit 0 of the new word lands at index 0.
        if (accept) begin
          word_d[0] = i_din;
          cnt_inc   = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          word_d[cnt] = i_din;
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = FULL;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      FULL: begin
        // Word is handed off only while enabled; serial input is ignored here.
        if (i_en && i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  // Reset gates o_ready directly: state reads IDLE during reset, which would otherwise show ready.
  assign o_ready      = i_en & ~i_rst & (state_q != FULL);
  assign o_dout_valid = (state_q == FULL);
  assign ov_dout      = word_q;

endmodule

// File: tb/tb_deserializer_fsm.sv
// Self-checking bench for deserializer_fsm with a word-level reference model.
// Latency: n/a (testbench).
// Backpressure: exercised via i_ready stalls, bubbles on i_din_valid and i_en freezes.
module tb_deserializer_fsm;

  localparam int L = 32;

  logic         tb_clk = 1'b0;
  logic         rst;
  logic         en;
  logic         din;
  logic         din_valid;
  logic         dn_ready;
  logic         o_ready;
  logic [L-1:0] ov_dout;
  logic         o_dout_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: number of bits collected so far, the word being built,
  // and whether a complete word is waiting for the downstream side.
  int           m_k;
  bit           m_full;
  logic [L-1:0] m_word;

  deserializer_fsm #(.LENGTH(L)) dut (
    .i_clk        (tb_clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .o_ready      (o_ready),
    .ov_dout      (ov_dout),
    .o_dout_valid (o_dout_valid),
    .i_ready      (dn_ready)
  );

  always #5 tb_clk = ~tb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic model_reset();
    m_k    = 0;
    m_full = 1'b0;
    m_word = '0;
  endtask

  // Apply the current inputs to the model, then move to 1 time unit past the next rising edge.
  task automatic cyc();
    if (en) begin
      if (m_full) begin
        if (dn_ready) begin
          m_full = 1'b0;
          m_k    = 0;
        end
      end else if (din_valid) begin
        m_word[m_k] = din;
        m_k++;
        if (m_k == L) m_full = 1'b1;
      end
    end
    @(posedge tb_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din       = b;
    din_valid = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; din = 1'b0; din_valid = 1'b0; dn_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge tb_clk);
    #1;
    n_checks++;
    if (o_dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", o_dout_valid); end
    n_checks++;
    if (ov_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h required 0", ov_dout); end
    n_checks++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", o_ready); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b required 1", o_ready); end
  endtask

  // Two words at the minimum period; a bit offered in the FULL cycle must be ignored.
  task automatic test_back_to_back();
    logic [L-1:0] w;
    dn_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? 32'h00FF00FF : 32'hFF00FF00;
      for (int i = 0; i < L; i++) begin
        send_bit(w[i]);
        n_checks++;
        if (o_dout_valid !== (i == L - 1)) begin
          n_fail++; $display("FAIL b2b_valid word %0d bit %0d: got %b required %b", n, i, o_dout_valid, (i == L - 1));
        end
        n_checks++;
        if (o_ready !== (i != L - 1)) begin
          n_fail++; $display("FAIL b2b_ready word %0d bit %0d: got %b required %b", n, i, o_ready, (i != L - 1));
        end
      end
      n_checks++;
      if (ov_dout !== w) begin n_fail++; $display("FAIL b2b_dout word %0d: got %h required %h", n, ov_dout, w); end
      send_bit(1'b1);
      n_checks++;
      if (o_dout_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_release word %0d: got %b required 0", n, o_dout_valid); end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_bubbles();
    logic [L-1:0] w;
    w = 32'hAF5EB9C3;
    dn_ready = 1'b1;
    for (int i = 0; i < L; i++) begin
      send_bit(w[i]);
      n_checks++;
      if (o_dout_valid !== (i == L - 1)) begin
        n_fail++; $display("FAIL bubble_valid bit %0d: got %b required %b", i, o_dout_valid, (i == L - 1));
      end
      if (i == 7 || i == 20) begin
        for (int b = 0; b < 3; b++) begin
          din_valid = 1'b0;
          din = 1'($urandom);
          cyc();
          n_checks++;
          if (o_dout_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL bubble_hold bit %0d: valid %b ready %b required 0 1", i, o_dout_valid, o_ready);
          end
        end
      end
    end
    n_checks++;
    if (ov_dout !== w) begin n_fail++; $display("FAIL bubble_dout: got %h required %h", ov_dout, w); end
    din_valid = 1'b0;
    cyc();
  endtask

  task automatic test_full_hold();
    logic [L-1:0] w;
    w = $urandom;
    dn_ready = 1'b0;
    for (int i = 0; i < L; i++) send_bit(w[i]);
    for (int c = 0; c < 10; c++) begin
      din_valid = 1'b1;
      din = ~din;
      cyc();
      n_checks++;
      if (o_ready !== 1'b0 || o_dout_valid !== 1'b1) begin
        n_fail++; $display("FAIL full_hold cycle %0d: ready %b valid %b required 0 1", c, o_ready, o_dout_valid);
      end
      n_checks++;
      if (ov_dout !== w) begin n_fail++; $display("FAIL full_dout cycle %0d: got %h required %h", c, ov_dout, w); end
    end
    dn_ready = 1'b1;
    din_valid = 1'b0;
    cyc();
    n_checks++;
    if (o_dout_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_release: valid %b ready %b required 0 1", o_dout_valid, o_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [L-1:0] w0;
    logic [L-1:0] w;
    w0 = $urandom | 32'h1;
    w  = 32'h12345678;
    dn_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_bit(w0[i]);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (o_dout_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b required 0", o_dout_valid); end
    n_checks++;
    if (ov_dout !== '0) begin n_fail++; $display("FAIL midrst_dout: got %h required 0", ov_dout); end
    n_checks++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b required 0", o_ready); end
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < L; i++) begin
      send_bit(w[i]);
      n_checks++;
      if (o_dout_valid !== (i == L - 1)) begin
        n_fail++; $display("FAIL midrst_word_valid bit %0d: got %b required %b", i, o_dout_valid, (i == L - 1));
      end
    end
    n_checks++;
    if (ov_dout !== w) begin n_fail++; $display("FAIL midrst_word_dout: got %h required %h", ov_dout, w); end
    din_valid = 1'b0;
    cyc();
  endtask

  task automatic test_enable_freeze();
    logic [L-1:0] w;
    w = 32'hC0DE5A71;
    dn_ready = 1'b1;
    for (int i = 0; i <= 10; i++) send_bit(w[i]);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      din_valid = 1'b1;
      din = 1'($urandom);
      cyc();
      n_checks++;
      if (o_ready !== 1'b0 || o_dout_valid !== 1'b0) begin
        n_fail++; $display("FAIL freeze_ctrl cycle %0d: ready %b valid %b required 0 0", c, o_ready, o_dout_valid);
      end
      n_checks++;
      if (ov_dout !== m_word || ov_dout[10:0] !== w[10:0]) begin
        n_fail++; $display("FAIL freeze_dout cycle %0d: got %h required %h", c, ov_dout, m_word);
      end
    end
    en = 1'b1;
    for (int i = 11; i < L; i++) begin
      send_bit(w[i]);
      n_checks++;
      if (o_dout_valid !== (i == L - 1)) begin
        n_fail++; $display("FAIL freeze_resume_valid bit %0d: got %b required %b", i, o_dout_valid, (i == L - 1));
      end
    end
    n_checks++;
    if (ov_dout !== w) begin n_fail++; $display("FAIL freeze_resume_dout: got %h required %h", ov_dout, w); end
    // A disabled cycle in FULL must not hand the word off even with i_ready high.
    en = 1'b0;
    din_valid = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if (o_dout_valid !== 1'b1 || ov_dout !== w) begin
      n_fail++; $display("FAIL freeze_full: valid %b dout %h required 1 %h", o_dout_valid, ov_dout, w);
    end
    en = 1'b1;
    cyc();
    n_checks++;
    if (o_dout_valid !== 1'b0) begin n_fail++; $display("FAIL freeze_full_release: got %b required 0", o_dout_valid); end
  endtask

  // Random words from a behavioural serializer with random bubbles, enables and stalls.
  task automatic test_loopback();
    logic [L-1:0] src;
    int           bi;
    int           budget;
    bit           done;
    for (int w = 0; w < 100; w++) begin
      src    = $urandom;
      bi     = 0;
      budget = 0;
      done   = 1'b0;
      while (!done) begin
        if (budget >= 400) begin
          n_checks++; n_fail++;
          $display("FAIL loopback_timeout word %0d: no handoff after %0d cycles, required within 400", w, budget);
          return;
        end
        en        = ($urandom_range(0, 15) != 0);
        din_valid = ($urandom_range(0, 3) != 0);
        din       = (bi < L) ? src[bi] : 1'($urandom);
        dn_ready  = 1'($urandom_range(0, 1));
        if (en && m_full && dn_ready) begin
          n_checks++;
          if (ov_dout !== src) begin n_fail++; $display("FAIL loopback_word %0d: got %h required %h", w, ov_dout, src); end
          done = 1'b1;
        end else if (en && din_valid && !m_full) begin
          bi++;
        end
        cyc();
        budget++;
        n_checks++;
        if (o_dout_valid !== m_full) begin
          n_fail++; $display("FAIL loopback_valid word %0d cycle %0d: got %b required %b", w, budget, o_dout_valid, m_full);
        end
        n_checks++;
        if (o_ready !== (en & !m_full)) begin
          n_fail++; $display("FAIL loopback_ready word %0d cycle %0d: got %b required %b", w, budget, o_ready, (en & !m_full));
        end
      end
    end
    en = 1'b1;
    din_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_full_hold();
    test_reset_mid_word();
    test_enable_freeze();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
